controleur_banc: RTL and testbench

Operand-fetch and write-back controller that sits in front of `banc_registre` and is the only block that drives its ports. It accepts decoded instructions over a valid/ready handshake and reads source operands through the register-file read ports. A 16-entry pending-write scoreboard stalls read-after-write and write-after-write hazards. Write-back results from the late pipeline are funnelled into the register-file write port, with same-cycle forwarding to the instruction being issued.

---
 rtl/controleur_banc.sv | 135 +++++++++++++
 tb/tb_controleur_banc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controleur_banc.sv
// controleur_banc: operand-fetch / write-back controller in front of banc_registre.
// Issues decoded instructions through a one-deep output register, tracks
// in-flight writes with a 16-bit scoreboard and forwards same-cycle write-back data.
module controleur_banc (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [3:0] IN_OP,
  input  logic       IN_WR,
  input  logic [3:0] IN_DST,
  input  logic       IN_UA,
  input  logic       IN_UB,
  input  logic [3:0] IN_SRA,
  input  logic [3:0] IN_SRB,
  output logic [3:0] aA,
  output logic [3:0] aB,
  input  logic [7:0] QA,
  input  logic [7:0] QB,
  output logic [3:0] aW,
  output logic       W,
  output logic [7:0] DATA,
  input  logic       WB_EN,
  input  logic [3:0] WB_ADDR,
  input  logic [7:0] WB_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [3:0] OUT_OP,
  output logic       OUT_WR,
  output logic [3:0] OUT_DST,
  output logic [7:0] OUT_VA,
  output logic [7:0] OUT_VB,
  output logic [4:0] PEND_CNT
);

  logic [15:0] pend_q, pend_d;
  logic [4:0]  pend_cnt_q, pend_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_op_q, out_op_d;
  logic        out_wr_q, out_wr_d;
  logic [3:0]  out_dst_q, out_dst_d;
  logic [7:0]  out_va_q, out_va_d;
  logic [7:0]  out_vb_q, out_vb_d;

  logic fwd_a, fwd_b;
  logic haz_a, haz_b, haz_w;
  logic acc;
  logic clr_hit, set_new;

  // Register-file ports are pure pass-through; the file commits on the same edge that clears pend.
  assign aA   = IN_SRA;
  assign aB   = IN_SRB;
  assign aW   = WB_ADDR;
  assign W    = WB_EN;
  assign DATA = WB_DATA;

  // A write-back landing this cycle both supplies the operand and releases a RAW hazard.
  assign fwd_a = WB_EN && (WB_ADDR == IN_SRA);
  assign fwd_b = WB_EN && (WB_ADDR == IN_SRB);
  assign haz_a = IN_UA && pend_q[IN_SRA] && !fwd_a;
  assign haz_b = IN_UB && pend_q[IN_SRB] && !fwd_b;
  // Only one outstanding write per register, so a pending destination always stalls.
  assign haz_w = IN_WR && pend_q[IN_DST];

  assign IN_READY = !(haz_a || haz_b || haz_w) && (!out_valid_q || OUT_READY);
  assign acc      = IN_VALID && IN_READY;

  // Output register: load on accept, drop valid when drained, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_wr_d    = out_wr_q;
    out_dst_d   = out_dst_q;
    out_va_d    = out_va_q;
    out_vb_d    = out_vb_q;
    if (acc) begin
      out_valid_d = 1'b1;
      out_op_d    = IN_OP;
      out_wr_d    = IN_WR;
      out_dst_d   = IN_DST;
      out_va_d    = IN_UA ? (fwd_a ? WB_DATA : QA) : 8'h00;
      out_vb_d    = IN_UB ? (fwd_b ? WB_DATA : QB) : 8'h00;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  // Scoreboard: clear on write-back first, then set for the accepted writer so the set wins.
  always_comb begin
    pend_d  = pend_q;
    clr_hit = 1'b0;
    set_new = 1'b0;
    if (WB_EN) begin
      clr_hit         = pend_q[WB_ADDR];
      pend_d[WB_ADDR] = 1'b0;
    end
    if (acc && IN_WR) begin
      set_new        = !pend_d[IN_DST];
      pend_d[IN_DST] = 1'b1;
    end
    pend_cnt_d = pend_cnt_q + {4'b0000, set_new} - {4'b0000, clr_hit};
  end

  // State registers; reset drops the in-flight instruction and every pending write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q      <= 16'h0000;
      pend_cnt_q  <= 5'd0;
      out_valid_q <= 1'b0;
      out_op_q    <= 4'h0;
      out_wr_q    <= 1'b0;
      out_dst_q   <= 4'h0;
      out_va_q    <= 8'h00;
      out_vb_q    <= 8'h00;
    end else begin
      pend_q      <= pend_d;
      pend_cnt_q  <= pend_cnt_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_wr_q    <= out_wr_d;
      out_dst_q   <= out_dst_d;
      out_va_q    <= out_va_d;
      out_vb_q    <= out_vb_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_OP    = out_op_q;
  assign OUT_WR    = out_wr_q;
  assign OUT_DST   = out_dst_q;
  assign OUT_VA    = out_va_q;
  assign OUT_VB    = out_vb_q;
  assign PEND_CNT  = pend_cnt_q;

endmodule

// File: tb/tb_controleur_banc.sv
// tb_controleur_banc: directed and randomized checks of controleur_banc against
// a behavioural model of the scoreboard, output register and register file.
module tb_controleur_banc;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID, IN_READY;
  logic [3:0] IN_OP;
  logic       IN_WR;
  logic [3:0] IN_DST;
  logic       IN_UA, IN_UB;
  logic [3:0] IN_SRA, IN_SRB;
  logic [3:0] aA, aB, aW;
  logic [7:0] QA, QB;
  logic       W;
  logic [7:0] DATA;
  logic       WB_EN;
  logic [3:0] WB_ADDR;
  logic [7:0] WB_DATA;
  logic       OUT_VALID, OUT_READY;
  logic [3:0] OUT_OP;
  logic       OUT_WR;
  logic [3:0] OUT_DST;
  logic [7:0] OUT_VA, OUT_VB;
  logic [4:0] PEND_CNT;

  int checks = 0;
  int errors = 0;

  // Register file stand-in, driven only through the DUT's write port.
  logic [7:0] rf [16];

  // Reference model state.
  bit         m_pend [16];
  bit         m_ov;
  logic [3:0] m_op;
  bit         m_wr;
  logic [3:0] m_dst;
  logic [7:0] m_va, m_vb;
  logic [7:0] m_rf [16];

  controleur_banc dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP), .IN_WR(IN_WR),
    .IN_DST(IN_DST), .IN_UA(IN_UA), .IN_UB(IN_UB), .IN_SRA(IN_SRA), .IN_SRB(IN_SRB),
    .aA(aA), .aB(aB), .QA(QA), .QB(QB), .aW(aW), .W(W), .DATA(DATA),
    .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_OP(OUT_OP), .OUT_WR(OUT_WR),
    .OUT_DST(OUT_DST), .OUT_VA(OUT_VA), .OUT_VB(OUT_VB), .PEND_CNT(PEND_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (W) rf[aW] <= DATA;
  assign QA = rf[aA];
  assign QB = rf[aB];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelCount();
    int c = 0;
    for (int i = 0; i < 16; i++) c += m_pend[i];
    return c;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    m_ov = 1'b0; m_op = 4'h0; m_wr = 1'b0; m_dst = 4'h0; m_va = 8'h00; m_vb = 8'h00;
  endtask

  task automatic checkRegs();
    checkOutput("out_valid", {31'd0, OUT_VALID}, {31'd0, m_ov});
    checkOutput("out_op", {28'd0, OUT_OP}, {28'd0, m_op});
    checkOutput("out_wr", {31'd0, OUT_WR}, {31'd0, m_wr});
    checkOutput("out_dst", {28'd0, OUT_DST}, {28'd0, m_dst});
    checkOutput("out_va", {24'd0, OUT_VA}, {24'd0, m_va});
    checkOutput("out_vb", {24'd0, OUT_VB}, {24'd0, m_vb});
    checkOutput("pend_cnt", {27'd0, PEND_CNT}, modelCount());
  endtask

  task automatic applyStimulus(input bit valid, input logic [3:0] op, input bit wr, input logic [3:0] dst,
                               input bit ua, input logic [3:0] sra, input bit ub, input logic [3:0] srb,
                               input bit wb_en, input logic [3:0] wb_addr, input logic [7:0] wb_data,
                               input bit out_ready);
    IN_VALID = valid; IN_OP = op; IN_WR = wr; IN_DST = dst;
    IN_UA = ua; IN_SRA = sra; IN_UB = ub; IN_SRB = srb;
    WB_EN = wb_en; WB_ADDR = wb_addr; WB_DATA = wb_data;
    OUT_READY = out_ready;
  endtask

  // One clock: check combinational outputs, advance the model, then check registers after the edge.
  task automatic runCycle(output bit obs_rdy);
    bit fa, fb, stall, rdy, acc;
    #1;
    fa    = WB_EN && (WB_ADDR == IN_SRA);
    fb    = WB_EN && (WB_ADDR == IN_SRB);
    stall = (IN_UA && m_pend[IN_SRA] && !fa) || (IN_UB && m_pend[IN_SRB] && !fb) ||
            (IN_WR && m_pend[IN_DST]);
    rdy   = !stall && (!m_ov || OUT_READY);
    obs_rdy = IN_READY;
    checkOutput("in_ready", {31'd0, IN_READY}, {31'd0, rdy});
    checkOutput("rd_addr_a", {28'd0, aA}, {28'd0, IN_SRA});
    checkOutput("rd_addr_b", {28'd0, aB}, {28'd0, IN_SRB});
    checkOutput("wr_en", {31'd0, W}, {31'd0, WB_EN});
    checkOutput("wr_addr", {28'd0, aW}, {28'd0, WB_ADDR});
    checkOutput("wr_data", {24'd0, DATA}, {24'd0, WB_DATA});
    acc = IN_VALID && rdy;
    if (acc) begin
      m_ov = 1'b1; m_op = IN_OP; m_wr = IN_WR; m_dst = IN_DST;
      m_va = IN_UA ? (fa ? WB_DATA : m_rf[IN_SRA]) : 8'h00;
      m_vb = IN_UB ? (fb ? WB_DATA : m_rf[IN_SRB]) : 8'h00;
    end else if (OUT_READY) begin
      m_ov = 1'b0;
    end
    if (WB_EN) begin
      m_pend[WB_ADDR] = 1'b0;
      m_rf[WB_ADDR]   = WB_DATA;
    end
    if (acc && IN_WR) m_pend[IN_DST] = 1'b1;
    @(posedge CLK);
    #1;
    checkRegs();
  endtask

  initial begin
    bit r;
    int q[$];
    bit wbe;
    logic [3:0] wba;

    RST = 1'b1;
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00, 1);
    modelReset();
    for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
    #12;
    checkRegs();
    checkOutput("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    $display("[TB] preloading register file");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 4'(i), 8'($urandom), 1);
      runCycle(r);
    end
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 4'd1, 8'h12, 1);
    runCycle(r);
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 4'd2, 8'h34, 1);
    runCycle(r);

    $display("[TB] back-to-back issue");
    applyStimulus(1, 4'd3, 1, 4'd5, 1, 4'd1, 1, 4'd2, 0, 4'h0, 8'h00, 1);
    runCycle(r);
    checkOutput("b2b_va", {24'd0, OUT_VA}, 32'h12);
    checkOutput("b2b_vb", {24'd0, OUT_VB}, 32'h34);
    checkOutput("b2b_dst", {28'd0, OUT_DST}, 32'd5);
    checkOutput("b2b_cnt", {27'd0, PEND_CNT}, 32'd1);

    $display("[TB] RAW stall and forward");
    applyStimulus(1, 4'd6, 0, 4'd0, 1, 4'd5, 0, 4'd0, 0, 4'h0, 8'h00, 1);
    runCycle(r);
    checkOutput("raw_stall", {31'd0, r}, 32'd0);
    applyStimulus(1, 4'd6, 0, 4'd0, 1, 4'd5, 0, 4'd0, 1, 4'd5, 8'hA7, 1);
    runCycle(r);
    checkOutput("raw_fwd_ready", {31'd0, r}, 32'd1);
    checkOutput("raw_fwd_va", {24'd0, OUT_VA}, 32'hA7);
    checkOutput("raw_fwd_cnt", {27'd0, PEND_CNT}, 32'd0);

    $display("[TB] WAW stall");
    applyStimulus(1, 4'd7, 1, 4'd7, 0, 4'd0, 0, 4'd0, 0, 4'h0, 8'h00, 1);
    runCycle(r);
    applyStimulus(1, 4'd9, 1, 4'd7, 0, 4'd0, 0, 4'd0, 0, 4'h0, 8'h00, 1);
    runCycle(r);
    checkOutput("waw_stall", {31'd0, r}, 32'd0);
    applyStimulus(1, 4'd9, 1, 4'd7, 0, 4'd0, 0, 4'd0, 1, 4'd7, 8'h55, 1);
    runCycle(r);
    checkOutput("waw_stall_wb", {31'd0, r}, 32'd0);
    applyStimulus(1, 4'd9, 1, 4'd7, 0, 4'd0, 0, 4'd0, 0, 4'h0, 8'h00, 1);
    runCycle(r);
    checkOutput("waw_accept", {31'd0, r}, 32'd1);
    checkOutput("waw_cnt", {27'd0, PEND_CNT}, 32'd1);
    checkOutput("waw_op", {28'd0, OUT_OP}, 32'd9);

    $display("[TB] backpressure");
    applyStimulus(1, 4'hC, 0, 4'd0, 1, 4'd1, 0, 4'd0, 0, 4'h0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      runCycle(r);
      checkOutput("bp_stall", {31'd0, r}, 32'd0);
      checkOutput("bp_hold_op", {28'd0, OUT_OP}, 32'd9);
      checkOutput("bp_hold_valid", {31'd0, OUT_VALID}, 32'd1);
    end
    applyStimulus(1, 4'hC, 0, 4'd0, 1, 4'd1, 0, 4'd0, 0, 4'h0, 8'h00, 1);
    runCycle(r);
    checkOutput("bp_release", {31'd0, r}, 32'd1);
    checkOutput("bp_next_op", {28'd0, OUT_OP}, 32'hC);
    checkOutput("bp_next_va", {24'd0, OUT_VA}, 32'h12);
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 4'd7, 8'h66, 1);
    runCycle(r);

    $display("[TB] same-register set/clear");
    applyStimulus(1, 4'd2, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 4'h0, 8'h00, 1);
    runCycle(r);
    applyStimulus(1, 4'd5, 1, 4'd3, 0, 4'd0, 0, 4'd0, 1, 4'd3, 8'h77, 1);
    runCycle(r);
    checkOutput("same_reg_stall", {31'd0, r}, 32'd0);
    applyStimulus(1, 4'd5, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 4'h0, 8'h00, 1);
    runCycle(r);
    checkOutput("same_reg_accept", {31'd0, r}, 32'd1);
    checkOutput("same_reg_cnt", {27'd0, PEND_CNT}, 32'd1);
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 4'd3, 8'h88, 1);
    runCycle(r);

    $display("[TB] reset mid-stream");
    for (int i = 8; i < 11; i++) begin
      applyStimulus(1, 4'(i), 1, 4'(i), 0, 4'd0, 0, 4'd0, 0, 4'h0, 8'h00, 1);
      runCycle(r);
    end
    checkOutput("pre_rst_cnt", {27'd0, PEND_CNT}, 32'd3);
    checkOutput("pre_rst_valid", {31'd0, OUT_VALID}, 32'd1);
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 8'h00, 0);
    #2;
    RST = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    checkOutput("rst_cnt", {27'd0, PEND_CNT}, 32'd0);
    checkOutput("rst_ready", {31'd0, IN_READY}, 32'd1);
    checkRegs();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    applyStimulus(0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 1, 4'd8, 8'h99, 1);
    runCycle(r);
    applyStimulus(1, 4'd1, 0, 4'd0, 1, 4'd8, 0, 4'd0, 0, 4'h0, 8'h00, 1);
    runCycle(r);
    checkOutput("post_rst_wb_va", {24'd0, OUT_VA}, 32'h99);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      q.delete();
      for (int i = 0; i < 16; i++) if (m_pend[i]) q.push_back(i);
      wbe = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) wba = 4'(q[$urandom_range(0, q.size() - 1)]);
      else wba = 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom), 4'($urandom),
                    1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                    wbe, wba, 8'($urandom), ($urandom_range(0, 4) != 0));
      runCycle(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
